// File: rtl/cnn_pkg.sv
// Shared encodings for the MNIST CNN schedulers: sequencer states, layer modes,
// default channel counts and picture dimensions per layer.
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_GO,
        S_CONV_WAIT,
        S_POOL_GO,
        S_POOL_WAIT,
        S_FC_GO,
        S_FC_WAIT,
        S_FINISH
    } seq_state_t;

    localparam logic MODE_L0 = 1'b0;
    localparam logic MODE_L1 = 1'b1;

    localparam int CH_L0_DEF = 4;
    localparam int CH_L1_DEF = 8;

    localparam int L0_IN_DIM   = 28;
    localparam int L0_CONV_DIM = 24;
    localparam int L0_POOL_DIM = 12;
    localparam int L1_IN_DIM   = 12;
    localparam int L1_CONV_DIM = 8;
    localparam int L1_POOL_DIM = 4;

    function automatic logic is_go(input seq_state_t s);
        return (s == S_CONV_GO) || (s == S_POOL_GO) || (s == S_FC_GO);
    endfunction

    function automatic logic is_wait(input seq_state_t s);
        return (s == S_CONV_WAIT) || (s == S_POOL_WAIT) || (s == S_FC_WAIT);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state timeout: counter cleared on arm, counts while active, sticky error at all-ones.
// expired is combinational from the registered count; no backpressure.
module seq_watchdog #(
    parameter int TMO_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic active,
    input  logic err_clr,
    output logic expired,
    output logic error
);

    logic [TMO_BIT-1:0] cnt;

    assign expired = active && (&cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            error <= 1'b0;
        end else begin
            if (arm) begin
                cnt <= '0;
            end else if (active && !(&cnt)) begin
                cnt <= cnt + 1'b1;
            end
            if (err_clr) begin
                error <= 1'b0;
            end else if (expired) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer: conv+pool per channel for layer 0 then layer 1, then FC; start -> conv_start next cycle.
// No backpressure: each stage waits for its done pulse; SEQ_WATCHDOG_EN adds a wait timeout with sticky error.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int CH_L0   = CH_L0_DEF,
    parameter int CH_L1   = CH_L1_DEF,
    parameter int CH_BIT  = 4,
    parameter int TMO_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              conv_done,
    input  logic              pool_done,
    input  logic              fc_done,
    output logic              conv_start,
    output logic              pool_start,
    output logic              fc_start,
    output logic              mode,
    output logic [CH_BIT-1:0] ch_idx,
    output logic              buf_sel,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [CH_BIT-1:0] L0_LAST = CH_BIT'(CH_L0 - 1);
    localparam logic [CH_BIT-1:0] L1_LAST = CH_BIT'(CH_L1 - 1);

    seq_state_t        state, state_nx;
    logic              mode_nx;
    logic [CH_BIT-1:0] ch_nx;
    logic              buf_nx;
    logic              timeout;

`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(
        .TMO_BIT (TMO_BIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .arm     (is_go(state)),
        .active  (is_wait(state)),
        .err_clr ((state == S_IDLE) && start),
        .expired (timeout),
        .error   (error)
    );
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    assign conv_start = (state == S_CONV_GO);
    assign pool_start = (state == S_POOL_GO);
    assign fc_start   = (state == S_FC_GO);
    assign done       = (state == S_FINISH);
    assign busy       = (state != S_IDLE) && (state != S_FINISH);

    always_comb begin
        state_nx = state;
        mode_nx  = mode;
        ch_nx    = ch_idx;
        buf_nx   = buf_sel;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_CONV_GO;
                    mode_nx  = MODE_L0;
                    ch_nx    = '0;
                    buf_nx   = 1'b0;
                end
            end
            S_CONV_GO: state_nx = S_CONV_WAIT;
            S_CONV_WAIT: begin
                if (conv_done) begin
                    state_nx = S_POOL_GO;
                    buf_nx   = ~buf_sel;
                end
            end
            S_POOL_GO: state_nx = S_POOL_WAIT;
            S_POOL_WAIT: begin
                if (pool_done) begin
                    buf_nx   = ~buf_sel;
                    state_nx = S_CONV_GO;
                    if (mode == MODE_L0) begin
                        if (ch_idx == L0_LAST) begin
                            mode_nx = MODE_L1;
                            ch_nx   = '0;
                        end else begin
                            ch_nx = ch_idx + 1'b1;
                        end
                    end else if (ch_idx == L1_LAST) begin
                        state_nx = S_FC_GO;
                    end else begin
                        ch_nx = ch_idx + 1'b1;
                    end
                end
            end
            S_FC_GO: state_nx = S_FC_WAIT;
            S_FC_WAIT: begin
                if (fc_done) begin
                    state_nx = S_FINISH;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        // A stalled scheduler aborts the run through FINISH so the CPU still sees done.
        if (timeout) begin
            state_nx = S_FINISH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mode    <= MODE_L0;
            ch_idx  <= '0;
            buf_sel <= 1'b0;
        end else begin
            state   <= state_nx;
            mode    <= mode_nx;
            ch_idx  <= ch_nx;
            buf_sel <= buf_nx;
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer with CH_L0=2, CH_L1=3; schedulers answer 5 cycles after start.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cnn_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       conv_done = 1'b0;
    logic       pool_done = 1'b0;
    logic       fc_done = 1'b0;
    logic       conv_start, pool_start, fc_start;
    logic       mode;
    logic [3:0] ch_idx;
    logic       buf_sel, busy, done, error;

    cnn_layer_sequencer #(
        .CH_L0   (2),
        .CH_L1   (3),
        .CH_BIT  (4),
        .TMO_BIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .conv_done  (conv_done),
        .pool_done  (pool_done),
        .fc_done    (fc_done),
        .conv_start (conv_start),
        .pool_start (pool_start),
        .fc_start   (fc_start),
        .mode       (mode),
        .ch_idx     (ch_idx),
        .buf_sel    (buf_sel),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         tog_cnt = 0;
    int         cyc = 0;
    int         ct = 0, pt = 0, ft = 0;
    bit         auto_en = 1'b0;
    logic       prev_buf = 1'b0;
    logic [7:0] log_q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] enc(input int kind, input int m, input int c);
        return {2'(kind), 1'(m), 1'b0, 4'(c)};
    endfunction

    // One clock cycle: log what the DUT shows this cycle, then drive this cycle's done inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        conv_done = 1'b0;
        pool_done = 1'b0;
        fc_done   = 1'b0;
        if (conv_start) log_q.push_back(enc(1, mode, ch_idx));
        if (pool_start) log_q.push_back(enc(2, mode, ch_idx));
        if (fc_start)   log_q.push_back(enc(3, mode, ch_idx));
        if (done) done_cnt++;
        if (buf_sel !== prev_buf) tog_cnt++;
        prev_buf = buf_sel;
        if (auto_en) begin
            if (conv_start) ct = 5;
            else if (ct > 0) begin ct--; if (ct == 0) conv_done = 1'b1; end
            if (pool_start) pt = 5;
            else if (pt > 0) begin pt--; if (pt == 0) pool_done = 1'b1; end
            if (fc_start) ft = 5;
            else if (ft > 0) begin ft--; if (ft == 0) fc_done = 1'b1; end
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        done_cnt = 0;
        tog_cnt  = 0;
        prev_buf = buf_sel;
        ct = 0; pt = 0; ft = 0;
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        int bad = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
            if (!done && !busy) bad++;
        end
        check("run_timeout", (done_cnt > d0), 1);
        check("busy_hold", bad, 0);
        check("busy_in_finish", busy, 0);
    endtask

    task automatic start_run();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_full_log(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            check(tag, (i < log_q.size()) ? log_q[i] : 8'hFF, exp_q[i]);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_toggles"}, tog_cnt, 10);
        check({tag, "_buf_end"}, buf_sel, 0);
    endtask

    initial begin
        int n;
        exp_q = '{enc(1,0,0), enc(2,0,0), enc(1,0,1), enc(2,0,1), enc(1,1,0), enc(2,1,0),
                  enc(1,1,1), enc(2,1,1), enc(1,1,2), enc(2,1,2), enc(3,1,2)};

        // Reset values
        rst = 1'b1;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_mode", mode, 0);
        check("rst_ch", ch_idx, 0);
        check("rst_buf", buf_sel, 0);
        check("rst_starts", {conv_start, pool_start, fc_start}, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst = 1'b0;
        clear_log();

        // Full run with start latency checks
        auto_en = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("lat_conv_start", conv_start, 1);
        check("lat_busy", busy, 1);
        step();
        check("conv_start_width", conv_start, 0);
        run_to_done(400);
        check("final_mode", mode, 1);
        check("final_ch", ch_idx, 2);
        check_full_log("order");
        step();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Spurious and simultaneous done pulses
        auto_en = 1'b0;
        clear_log();
        start_run();
        check("sp_go", conv_start, 1);
        conv_done = 1'b1;
        step();
        check("sp_go_done_pool", pool_start, 0);
        check("sp_go_done_buf", buf_sel, 0);
        pool_done = 1'b1;
        step();
        check("sp_pool_in_conv", pool_start, 0);
        check("sp_pool_in_conv_buf", buf_sel, 0);
        check("sp_pool_in_conv_ch", ch_idx, 0);
        check("sp_busy", busy, 1);
        conv_done = 1'b1;
        step();
        check("sp_pool_go", pool_start, 1);
        check("sp_buf1", buf_sel, 1);
        auto_en = 1'b1;
        step();
        conv_done = 1'b1;
        pool_done = 1'b1;
        step();
        check("sp_both_conv", conv_start, 1);
        check("sp_both_ch", ch_idx, 1);
        check("sp_both_mode", mode, 0);
        check("sp_both_buf", buf_sel, 0);
        run_to_done(400);
        check_full_log("sp_order");

        // start during POOL_WAIT is ignored
        clear_log();
        start_run();
        n = 0;
        while (!pool_start && n < 100) begin step(); n++; end
        check("rs_pool_seen", pool_start, 1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(400);
        for (int i = 0; i < 12; i++) step();
        check("rs_no_restart", busy, 0);
        check_full_log("rs_order");

        // Reset mid-run in layer 1 channel 1
        clear_log();
        start_run();
        n = 0;
        while (!(conv_start && mode && ch_idx == 4'd1) && n < 300) begin step(); n++; end
        check("mr_reach", {conv_start, mode, ch_idx}, {1'b1, 1'b1, 4'd1});
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ct = 0; pt = 0; ft = 0;
        check("mr_busy", busy, 0);
        check("mr_mode", mode, 0);
        check("mr_ch", ch_idx, 0);
        check("mr_buf", buf_sel, 0);
        check("mr_starts", {conv_start, pool_start, fc_start}, 0);
        step();
        check("mr_idle_starts", {conv_start, pool_start, fc_start}, 0);
        clear_log();
        start_run();
        run_to_done(400);
        check_full_log("mr_order");

`ifdef SEQ_WATCHDOG_EN
        // Watchdog: conv_done never arrives
        begin
            int e_cyc;
            int d_cyc;
            auto_en = 1'b0;
            clear_log();
            start_run();
            step();
            e_cyc = cyc;
            d_cyc = -1;
            n = 0;
            while (d_cyc < 0 && n < 40) begin
                if (done) d_cyc = cyc;
                else begin step(); n++; end
            end
            check("wd_done_seen", (d_cyc >= 0), 1);
            check("wd_latency", ((d_cyc - e_cyc) >= 15) && ((d_cyc - e_cyc) <= 16), 1);
            check("wd_error", error, 1);
            step();
            check("wd_idle", busy, 0);
            check("wd_sticky", error, 1);
            start_run();
            check("wd_err_clr", error, 0);
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
